// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq.
// master = decode/write-back side, slave = the unit.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_opcode;
  logic [WIDTH-1:0] i_data1;
  logic [WIDTH-1:0] i_data2;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [3:0]       o_flags;

  modport master (
    output i_valid, i_opcode, i_data1, i_data2,
    input  o_ready, o_valid, o_data, o_flags
  );

  modport slave (
    input  i_valid, i_opcode, i_data1, i_data2,
    output o_ready, o_valid, o_data, o_flags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with {N,Z,C,V} flags; ALU_SEQ_MUL_EN
// adds an iterative shift-add multiplier on opcode 9.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_seq_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] a, b;
  logic             accept;
  logic             ready;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic             c, v;

  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;

  assign a      = bus.i_data1;
  assign b      = bus.i_data2;
  assign accept = bus.i_valid & ready;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.i_opcode)
      4'd0: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        res = dif[MSB:0];
        c   = dif[WIDTH];
        v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      // Shift amount is the whole of B; oversize shifts flush or sign-fill
      4'd5: res = a >> b;
      4'd6: res = a << b;
      4'd7: res = $unsigned($signed(a) >>> b);
      4'd8: res = a;
      default: res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign ready = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.i_opcode == 4'd9) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = MUL_BUSY;
          end else begin
            data_d  = res;
            flags_d = {res[MSB], res == '0, c, v};
            valid_d = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          data_d  = acc_d[MSB:0];
          flags_d = {acc_d[MSB], acc_d[MSB:0] == '0,
                     |acc_d[2*WIDTH-1:WIDTH], 1'b0};
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign ready = 1'b1;

  always_comb begin
    data_d  = data_q;
    flags_d = flags_q;
    valid_d = accept;
    if (accept) begin
      data_d  = res;
      flags_d = {res[MSB], res == '0, c, v};
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=16.
// Multiplier sequences are built only with ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [3:0]  f;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  function automatic vec_t mk(input logic [3:0] op,
                              input logic [15:0] a, b, d,
                              input logic [3:0] f);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.d = d; t.f = f;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] op,
                       input logic [15:0] a, b);
    bus.i_valid  = vld;
    bus.i_opcode = op;
    bus.i_data1  = a;
    bus.i_data2  = b;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul_seq(input logic [15:0] a, b, d,
                         input logic [3:0] f);
    int cyc;
    @(negedge clk);
    drive(1'b1, 4'd9, a, b);
    @(negedge clk);
    drive(1'b1, 4'd0, 16'h1111, 16'h2222);
    cyc = 1;
    while (bus.o_valid !== 1'b1 && cyc < 40) begin
      chk("mul busy ready", {31'd0, bus.o_ready}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    bus.i_valid = 1'b0;
    chk("mul latency", cyc, 32'd17);
    chk("mul data", {16'd0, bus.o_data}, {16'd0, d});
    chk("mul flags", {28'd0, bus.o_flags}, {28'd0, f});
    chk("mul ready after", {31'd0, bus.o_ready}, 32'd1);
    @(negedge clk);
    chk("busy add dropped", {31'd0, bus.o_valid}, 32'd0);
  endtask
`endif

  initial begin
    vec_t vt[$];
    int   pulses;

    vt.push_back(mk(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110));
    vt.push_back(mk(4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001));
    vt.push_back(mk(4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010));
    vt.push_back(mk(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001));
    vt.push_back(mk(4'd5, 16'h8001, 16'd1,    16'h4000, 4'b0000));
    vt.push_back(mk(4'd7, 16'h8001, 16'd4,    16'hF800, 4'b1000));
    vt.push_back(mk(4'd6, 16'h8001, 16'd16,   16'h0000, 4'b0100));
    vt.push_back(mk(4'd7, 16'h8001, 16'd20,   16'hFFFF, 4'b1000));
    vt.push_back(mk(4'd6, 16'h8001, 16'd1,    16'h0002, 4'b0000));
    vt.push_back(mk(4'd5, 16'h8001, 16'hFFFF, 16'h0000, 4'b0100));
    vt.push_back(mk(4'd7, 16'h4001, 16'd16,   16'h0000, 4'b0100));
    vt.push_back(mk(4'd7, 16'h4001, 16'd15,   16'h0000, 4'b0100));
    vt.push_back(mk(4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000));
    vt.push_back(mk(4'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b1000));
    vt.push_back(mk(4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100));
    vt.push_back(mk(4'd8, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000));
    vt.push_back(mk(4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100));
    vt.push_back(mk(4'd15, 16'h8000, 16'h8000, 16'h0000, 4'b0100));
`ifndef ALU_SEQ_MUL_EN
    vt.push_back(mk(4'd9, 16'h0100, 16'h0101, 16'h0000, 4'b0100));
`endif

    drive(1'b0, 4'd0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst data", {16'd0, bus.o_data}, 32'd0);
    chk("rst flags", {28'd0, bus.o_flags}, 32'd0);
    chk("rst ready", {31'd0, bus.o_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b);
      @(negedge clk);
      bus.i_valid = 1'b0;
      chk($sformatf("v%0d valid", i), {31'd0, bus.o_valid}, 32'd1);
      chk($sformatf("v%0d data", i), {16'd0, bus.o_data}, {16'd0, vt[i].d});
      chk($sformatf("v%0d flags", i), {28'd0, bus.o_flags}, {28'd0, vt[i].f});
      chk($sformatf("v%0d ready", i), {31'd0, bus.o_ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d pulse end", i), {31'd0, bus.o_valid}, 32'd0);
      chk($sformatf("v%0d hold", i), {16'd0, bus.o_data}, {16'd0, vt[i].d});
    end

    // Back-to-back: one accept per cycle, one pulse per cycle
    drive(1'b1, 4'd2, 16'hFF00, 16'h0FF0);
    @(negedge clk);
    chk("b2b and v", {31'd0, bus.o_valid}, 32'd1);
    chk("b2b and d", {16'd0, bus.o_data}, 32'h0F00);
    chk("b2b and f", {28'd0, bus.o_flags}, 32'b0000);
    drive(1'b1, 4'd3, 16'hFF00, 16'h00FF);
    @(negedge clk);
    chk("b2b or v", {31'd0, bus.o_valid}, 32'd1);
    chk("b2b or d", {16'd0, bus.o_data}, 32'hFFFF);
    chk("b2b or f", {28'd0, bus.o_flags}, 32'b1000);
    drive(1'b1, 4'd4, 16'hFF00, 16'hFF00);
    @(negedge clk);
    chk("b2b xor v", {31'd0, bus.o_valid}, 32'd1);
    chk("b2b xor d", {16'd0, bus.o_data}, 32'h0000);
    chk("b2b xor f", {28'd0, bus.o_flags}, 32'b0100);
    drive(1'b1, 4'd8, 16'h8000, 16'h0000);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("b2b mov v", {31'd0, bus.o_valid}, 32'd1);
    chk("b2b mov d", {16'd0, bus.o_data}, 32'h8000);
    chk("b2b mov f", {28'd0, bus.o_flags}, 32'b1000);
    @(negedge clk);
    chk("b2b end", {31'd0, bus.o_valid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
    mul_seq(16'h0100, 16'h0101, 16'h0100, 4'b0010);
    mul_seq(16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010);
    mul_seq(16'h0003, 16'h0005, 16'h000F, 4'b0000);
    mul_seq(16'h0000, 16'h1234, 16'h0000, 4'b0100);
    mul_seq(16'h00FF, 16'h0081, 16'h807F, 4'b1000);
`endif

    // Reset mid-operation: outputs clear at once, no stray pulse
    drive(1'b1, 4'd8, 16'h1234, 16'h0000);
    @(negedge clk);
    bus.i_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    drive(1'b1, 4'd9, 16'h0003, 16'h0005);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort pre ready", {31'd0, bus.o_ready}, 32'd0);
`endif
    chk("abort pre data", {16'd0, bus.o_data}, 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("abort data", {16'd0, bus.o_data}, 32'd0);
    chk("abort flags", {28'd0, bus.o_flags}, 32'd0);
    chk("abort valid", {31'd0, bus.o_valid}, 32'd0);
    chk("abort ready", {31'd0, bus.o_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) pulses++;
    end
    chk("abort no pulse", pulses, 32'd0);
    chk("abort ready after", {31'd0, bus.o_ready}, 32'd1);
    chk("abort data after", {16'd0, bus.o_data}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's combinational ALU. Accepts one operation per cycle through a valid/ready handshake, registers the result with a status-flag word, and adds an iterative shift-add multiplier that occupies the unit for several cycles. Sits between the decode stage and register write-back.

## Interface

- WIDTH, 16, datapath width in bits; minimum 4.
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operation request; sampled only while o_ready=1.
- o_ready  output  1  unit can accept an operation this cycle.
- i_opcode  input  4  operation select; encodings under Operation.
- i_data1  input  WIDTH  operand A.
- i_data2  input  WIDTH  operand B, or shift amount.
- o_valid  output  1  one-cycle pulse: o_data/o_flags are new this cycle.
- o_data  output  WIDTH  registered result; held between pulses.
- o_flags  output  4  {N, Z, C, V}, registered with o_data.

## Operation

- Accept = i_valid & o_ready at a rising edge; operands and opcode are captured at that edge.
- Opcodes:
  - 0 ADD: A+B; C = carry out; V = signed overflow.
  - 1 SUB: A−B; C = borrow (1 iff A<B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SHR: logical right shift by B.
  - 6 SHL: left shift by B.
  - 7 ASR: arithmetic right shift by B.
  - 8 MOVE: A.
  - 9 MUL: low WIDTH bits of A×B, both operands unsigned; C = 1 iff the upper WIDTH bits of the product are nonzero.
  - 10–15: result 0; unit stays idle.
- Shifts take B as a full unsigned value. If B ≥ WIDTH, SHR and SHL give 0 and ASR gives all copies of A's MSB. C=V=0.
- C=V=0 for every op not listed above. N = result MSB. Z = (result == 0), for all ops.
- State machine: IDLE, MUL_BUSY.
  - IDLE: o_ready=1. A non-MUL accept registers its result at the same edge and asserts o_valid for the next cycle. A MUL accept loads the multiplicand, multiplier, accumulator and counter=WIDTH, then goes to MUL_BUSY.
  - MUL_BUSY: o_ready=0. Each cycle: add the shifted multiplicand if multiplier LSB=1, shift, decrement the counter. When the counter reaches 0: write o_data/o_flags, pulse o_valid, return to IDLE.
- No backpressure. The consumer must take o_data while o_valid is high. o_data stays valid until the next pulse.

## Timing

- Reset (async assert, synchronous deassert upstream): o_data=0, o_flags=0, o_valid=0, o_ready=1, state IDLE.
- Non-MUL latency: accept at edge N, o_valid high during cycle N+1. Back-to-back accepts give o_valid on consecutive cycles.
- MUL latency: accept at edge N, o_ready low from cycle N+1 through N+WIDTH, o_valid high in cycle N+WIDTH+1.
  - o_ready=1 again in cycle N+WIDTH+1, so a new op may be accepted in that same cycle.
- i_valid while o_ready=0 is ignored; the requester holds or retries.
- Reset asserted during MUL_BUSY aborts the multiply. No o_valid is produced and all outputs return to their reset values.
- Opcodes 10–15 still produce an o_valid pulse with o_data=0 and flags {0,1,0,0}.

## Configuration

- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 9 is the iterative multiplier described above.
- Undefined: no multiplier logic is built. Opcode 9 behaves as opcodes 10–15: single-cycle, result 0, Z=1. o_ready is constantly 1 outside reset, and MUL_BUSY does not exist.

## Test plan

- Reset then ADD 0xFFFF+0x0001 (WIDTH=16) -> next cycle o_valid=1, o_data=0x0000, flags N=0 Z=1 C=1 V=0.
- SUB 0x8000−0x0001 -> o_data=0x7FFF, N=0 Z=0 C=0 V=1. Then SUB 0x0003−0x0005 -> 0xFFFE, N=1 C=1 V=0.
- Shifts on A=0x8001: SHR by 1 -> 0x4000; ASR by 4 -> 0xF800; SHL by 16 -> 0x0000 Z=1; ASR by 20 -> 0xFFFF.
- With ALU_SEQ_MUL_EN: MUL 0x0100×0x0101 -> o_ready low for 16 cycles, then o_data=0x0100, C=1, o_valid on cycle 17. An ADD presented during busy is not accepted.
- Back-to-back AND, OR, XOR, MOVE on consecutive cycles -> four consecutive o_valid pulses with the correct results.
- Assert i_rst_n low at busy cycle 5 of a MUL -> outputs zero immediately, no o_valid, o_ready=1 after release.
